// File: rtl/ula_pkg.sv
// ula_pkg: shared opcode map, flag bit positions and FSM state type for ula_seq.
//   OP_*     : 4-bit opcodes
//   FLAG_*   : bit positions inside the {V,C,S,Z} flag nibble
//   state_t  : handshake FSM states
//   pack_flags : builds the flag nibble from its four bits
package ula_pkg;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_MOD  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_NOR  = 4'hA;
    localparam logic [3:0] OP_NAND = 4'hB;
    localparam logic [3:0] OP_XNOR = 4'hC;

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    function automatic logic [3:0] pack_flags(input logic z, input logic s, input logic c, input logic v);
        logic [3:0] f;
        f = '0;
        f[FLAG_Z] = z;
        f[FLAG_S] = s;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction
endpackage

// File: rtl/ula_seq_if.sv
// ula_seq_if: valid/ready request and response bundle for ula_seq.
//   master: drives in_valid, ula_operation, operand1, operand2, out_ready
//   slave : drives in_ready, out_valid, result, flags ({V,C,S,Z}), err
interface ula_seq_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ula_operation;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             err;

    modport master (
        output in_valid, ula_operation, operand1, operand2, out_ready,
        input  in_ready, out_valid, result, flags, err
    );
    modport slave (
        input  in_valid, ula_operation, operand1, operand2, out_ready,
        output in_ready, out_valid, result, flags, err
    );
endinterface

// File: rtl/ula_iter_unit.sv
// ula_iter_unit: WIDTH-cycle shift-add multiplier / restoring divider.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load a/b and begin WIDTH iterations
//   div_mode   : 0 = multiply, 1 = divide (sampled on start)
//   a, b       : multiplier/dividend and multiplicand/divisor
//   done       : high during the last iteration
//   acc_hi/lo  : accumulator after the current iteration
//                (mul: product hi/lo; div: remainder/quotient)
// Divider datapath only exists when ULA_DIVMOD_EN is defined.
module ula_iter_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);
    import ula_pkg::*;
    localparam int CW = $clog2(WIDTH) + 1;
    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, dvs;
    logic [WIDTH:0]   add;

    // The FSM latches acc_hi/acc_lo on the done cycle, so outputs are the post-step values.
    assign done = busy && cnt == CW'(WIDTH - 1);
    assign add = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);

`ifdef ULA_DIVMOD_EN
    logic           mode;
    logic [WIDTH:0] shl, sub;
    assign shl = {hi, lo[WIDTH-1]};
    assign sub = shl - {1'b0, dvs};
    always_comb begin
        {acc_hi, acc_lo} = {add, lo[WIDTH-1:1]};
        if (mode) {acc_hi, acc_lo} = {sub[WIDTH] ? shl[WIDTH-1:0] : sub[WIDTH-1:0], lo[WIDTH-2:0], ~sub[WIDTH]};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mode <= 1'b0;
        else if (start) mode <= div_mode;
    end
`else
    logic unused_mode;
    assign unused_mode = div_mode;
    assign {acc_hi, acc_lo} = {add, lo[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            dvs  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            hi   <= '0;
            lo   <= a;
            dvs  <= b;
        end else if (busy) begin
            hi   <= acc_hi;
            lo   <= acc_lo;
            cnt  <= done ? '0 : cnt + 1'b1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/ula_seq.sv
// ula_seq: multi-cycle ALU with valid/ready handshake on both sides.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : ula_seq_if slave (in_valid/in_ready, ula_operation, operand1/2,
//                out_valid/out_ready, result, flags {V,C,S,Z}, err)
// Single-cycle ops complete on the accept edge; MUL (and DIV/MOD with B!=0)
// take WIDTH further cycles in ula_iter_unit.
// Define ULA_DIVMOD_EN to implement DIV/MOD; otherwise they are invalid opcodes.
module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    ula_seq_if.slave bus
);
    import ula_pkg::*;
`ifdef ULA_DIVMOD_EN
    localparam bit HAS_DIV = 1'b1;
`else
    localparam bit HAS_DIV = 1'b0;
`endif
    state_t           state;
    logic [3:0]       op, op_q, flags1, flags2;
    logic [WIDTH-1:0] a, b, res1, res2, acc_hi, acc_lo;
    logic [WIDTH:0]   sum, dif;
    logic             c1, v1, err1, inv, is_div, multi, accept, done, mul_ovf;

    assign op = bus.ula_operation;
    assign a = bus.operand1;
    assign b = bus.operand2;
    assign bus.in_ready = (state == ST_IDLE) || (state == ST_DONE && bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;
    assign is_div = HAS_DIV && (op == OP_DIV || op == OP_MOD);
    // Divide-by-zero skips the iterations and completes like a single-cycle op.
    assign multi = op == OP_MUL || (is_div && b != '0);
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        res1 = '0;
        c1   = 1'b0;
        v1   = 1'b0;
        err1 = 1'b0;
        inv  = 1'b0;
        case (op)
            OP_ADD: begin
                res1 = sum[WIDTH-1:0];
                c1   = sum[WIDTH];
                v1   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res1 = dif[WIDTH-1:0];
                c1   = dif[WIDTH];
                v1   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL:  res1 = '0;
            OP_AND:  res1 = a & b;
            OP_OR:   res1 = a | b;
            OP_XOR:  res1 = a ^ b;
            OP_NOT:  res1 = ~a;
            OP_NOR:  res1 = ~(a | b);
            OP_NAND: res1 = ~(a & b);
            OP_XNOR: res1 = ~(a ^ b);
            OP_DIV, OP_MOD: begin
                if (HAS_DIV) begin
                    res1 = op == OP_DIV ? '1 : a;
                    v1   = 1'b1;
                    err1 = 1'b1;
                end else inv = 1'b1;
            end
            default: inv = 1'b1;
        endcase
        flags1 = inv ? 4'b0 : pack_flags(res1 == '0, res1[WIDTH-1], c1, v1);
    end

    assign res2 = op_q == OP_MOD ? acc_hi : acc_lo;
    assign mul_ovf = op_q == OP_MUL && acc_hi != '0;
    assign flags2 = pack_flags(res2 == '0, res2[WIDTH-1], mul_ovf, mul_ovf);

    ula_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (accept && multi),
        .div_mode (op != OP_MUL),
        .a        (a),
        .b        (b),
        .done     (done),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            op_q          <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.flags     <= '0;
            bus.err       <= 1'b0;
        end else if (accept) begin
            op_q          <= op;
            state         <= multi ? ST_BUSY : ST_DONE;
            bus.out_valid <= !multi;
            if (!multi) begin
                bus.result <= res1;
                bus.flags  <= flags1;
                bus.err    <= err1 || inv;
            end
        end else if (state == ST_DONE && bus.out_ready) begin
            state         <= ST_IDLE;
            bus.out_valid <= 1'b0;
        end else if (state == ST_BUSY && done) begin
            state         <= ST_DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= res2;
            bus.flags     <= flags2;
            bus.err       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: self-checking bench for ula_seq (WIDTH=8 and WIDTH=16 instances).
// Expectations follow ULA_DIVMOD_EN the same way the design does.
module tb_ula_seq;
    import ula_pkg::*;
`ifdef ULA_DIVMOD_EN
    localparam bit DIVMOD = 1'b1;
`else
    localparam bit DIVMOD = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
        logic [31:0] lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ula_seq_if #(.WIDTH(8))  b8 ();
    ula_seq_if #(.WIDTH(16)) b16 ();
    ula_seq #(.WIDTH(8))  dut   (.clk(clk), .reset(reset), .bus(b8));
    ula_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));

    int checks = 0;
    int errors = 0;
    vec_t tv[15];
    vec_t ex;
    logic [3:0]  rop, f;
    logic [7:0]  ra, rb, r;
    logic [15:0] ra16, rb16, r16;
    logic        e, seen;
    int          lat;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic vec_t model(input int w, input logic [3:0] op, input longint a, input longint b);
        vec_t v;
        longint m, half, sa, sb, r;
        bit c, ov, er, inv;
        m = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa = a >= half ? a - 2 * half : a;
        sb = b >= half ? b - 2 * half : b;
        c = 0; ov = 0; er = 0; inv = 0; r = 0;
        v.op = op; v.a = a[31:0]; v.b = b[31:0]; v.lat = 1;
        case (op)
            OP_ADD: begin r = a + b; c = r > m; ov = (sa + sb) >= half || (sa + sb) < -half; end
            OP_SUB: begin r = a - b; c = a < b; ov = (sa - sb) >= half || (sa - sb) < -half; end
            OP_MUL: begin r = a * b; c = (r >> w) != 0; ov = c; v.lat = w + 1; end
            OP_DIV, OP_MOD: begin
                if (!DIVMOD) inv = 1;
                else if (b == 0) begin r = op == OP_DIV ? m : a; ov = 1; er = 1; end
                else begin r = op == OP_DIV ? a / b : a % b; v.lat = w + 1; end
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_NOR:  r = ~(a | b);
            OP_NAND: r = ~(a & b);
            OP_XNOR: r = ~(a ^ b);
            default: inv = 1;
        endcase
        r = r & m;
        v.res = inv ? 32'd0 : r[31:0];
        v.flg = inv ? 4'b0 : {ov, c, r >= half, r == 0};
        v.err = er || inv;
        return v;
    endfunction

    // Issue one request; lat counts edges from the accept edge to out_valid.
    task automatic op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int hold,
                       output logic [7:0] res, output logic [3:0] flg, output logic er, output int l);
        int n;
        b8.out_ready = 1'b1;
        #1;
        n = 0;
        while (!b8.in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready before request", b8.in_ready, 1);
        b8.in_valid = 1'b1;
        b8.ula_operation = op;
        b8.operand1 = a;
        b8.operand2 = b;
        l = 0;
        do begin
            @(posedge clk); #1;
            l++;
            b8.in_valid = 1'b0;
            b8.ula_operation = 4'($urandom);
            b8.operand1 = ~a;
            b8.operand2 = ~b;
        end while (!b8.out_valid && l < 100);
        res = b8.result;
        flg = b8.flags;
        er = b8.err;
        if (hold > 0) begin
            b8.out_ready = 1'b0;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("held output stable", {b8.out_valid, b8.in_ready, b8.result, b8.flags, b8.err}, {1'b1, 1'b0, res, flg, er});
            end
            b8.out_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic op16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic [3:0] flg, output logic er, output int l);
        b16.out_ready = 1'b1;
        #1;
        chk("w16 in_ready", b16.in_ready, 1);
        b16.in_valid = 1'b1;
        b16.ula_operation = op;
        b16.operand1 = a;
        b16.operand2 = b;
        l = 0;
        do begin
            @(posedge clk); #1;
            l++;
            b16.in_valid = 1'b0;
            b16.operand1 = ~a;
        end while (!b16.out_valid && l < 100);
        res = b16.result;
        flg = b16.flags;
        er = b16.err;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{OP_ADD,  32'h7F, 32'h01, 32'h80, 4'b1010, 1'b0, 32'd1};
        tv[1]  = '{OP_MUL,  32'h10, 32'h10, 32'h00, 4'b1101, 1'b0, 32'd9};
`ifdef ULA_DIVMOD_EN
        tv[2]  = '{OP_DIV,  32'd200, 32'd7, 32'd28, 4'b0000, 1'b0, 32'd9};
        tv[3]  = '{OP_MOD,  32'd200, 32'd7, 32'd4,  4'b0000, 1'b0, 32'd9};
        tv[4]  = '{OP_DIV,  32'd5,   32'd0, 32'hFF, 4'b1010, 1'b1, 32'd1};
        tv[5]  = '{OP_MOD,  32'd9,   32'd0, 32'd9,  4'b1000, 1'b1, 32'd1};
`else
        tv[2]  = '{OP_DIV,  32'd200, 32'd7, 32'd0, 4'b0000, 1'b1, 32'd1};
        tv[3]  = '{OP_MOD,  32'd200, 32'd7, 32'd0, 4'b0000, 1'b1, 32'd1};
        tv[4]  = '{OP_DIV,  32'd5,   32'd0, 32'd0, 4'b0000, 1'b1, 32'd1};
        tv[5]  = '{OP_MOD,  32'd9,   32'd0, 32'd0, 4'b0000, 1'b1, 32'd1};
`endif
        tv[6]  = '{4'hF,    32'h12, 32'h34, 32'h00, 4'b0000, 1'b1, 32'd1};
        tv[7]  = '{4'h0,    32'hAA, 32'h55, 32'h00, 4'b0000, 1'b1, 32'd1};
        tv[8]  = '{OP_SUB,  32'h00, 32'h01, 32'hFF, 4'b0110, 1'b0, 32'd1};
        tv[9]  = '{OP_SUB,  32'h80, 32'h01, 32'h7F, 4'b1000, 1'b0, 32'd1};
        tv[10] = '{OP_ADD,  32'hFF, 32'h01, 32'h00, 4'b0101, 1'b0, 32'd1};
        tv[11] = '{OP_NOT,  32'hFF, 32'h00, 32'h00, 4'b0001, 1'b0, 32'd1};
        tv[12] = '{OP_MUL,  32'hFF, 32'hFF, 32'h01, 4'b1100, 1'b0, 32'd9};
        tv[13] = '{OP_NOR,  32'h00, 32'h00, 32'hFF, 4'b0010, 1'b0, 32'd1};
        tv[14] = '{OP_NAND, 32'hFF, 32'h0F, 32'hF0, 4'b0010, 1'b0, 32'd1};

        reset = 1'b1;
        b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.ula_operation = '0; b8.operand1 = '0; b8.operand2 = '0;
        b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.ula_operation = '0; b16.operand1 = '0; b16.operand2 = '0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {b8.out_valid, b8.result, b8.flags, b8.err}, 0);
        chk("reset in_ready", b8.in_ready, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post-reset outputs", {b8.out_valid, b8.result, b8.flags, b8.err}, 0);
        chk("w16 post-reset outputs", {b16.out_valid, b16.result, b16.flags, b16.err}, 0);
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            op8(tv[i].op, tv[i].a[7:0], tv[i].b[7:0], 0, r, f, e, lat);
            chk($sformatf("vec%0d result", i), r, tv[i].res);
            chk($sformatf("vec%0d flags", i), f, tv[i].flg);
            chk($sformatf("vec%0d err", i), e, tv[i].err);
            chk($sformatf("vec%0d latency", i), lat, tv[i].lat);
        end

        // Back-to-back single-cycle ops: one result per cycle.
        b8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rop = i == 0 ? OP_XOR : i == 1 ? OP_AND : OP_OR;
            ra = 8'($urandom); rb = 8'($urandom);
            b8.in_valid = 1'b1; b8.ula_operation = rop; b8.operand1 = ra; b8.operand2 = rb;
            @(posedge clk); #1;
            ex = model(8, rop, ra, rb);
            chk($sformatf("b2b%0d out_valid", i), b8.out_valid, 1);
            chk($sformatf("b2b%0d result", i), b8.result, ex.res);
            @(negedge clk);
        end
        b8.in_valid = 1'b0;
        @(negedge clk);

        // Stalled consumer: first result held, new request not accepted.
        b8.out_ready = 1'b0;
        b8.in_valid = 1'b1; b8.ula_operation = OP_XOR; b8.operand1 = 8'h3C; b8.operand2 = 8'h0F;
        @(negedge clk);
        b8.ula_operation = OP_AND; b8.operand1 = 8'hF0; b8.operand2 = 8'h3C;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall hold", {b8.out_valid, b8.in_ready, b8.result}, {1'b1, 1'b0, 8'h33});
        end
        @(negedge clk);
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall release next result", {b8.out_valid, b8.result}, {1'b1, 8'h30});
        b8.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset three cycles into a MUL discards it.
        b8.in_valid = 1'b1; b8.ula_operation = OP_MUL; b8.operand1 = 8'h10; b8.operand2 = 8'h10;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("abort reset outputs", {b8.out_valid, b8.result, b8.flags, b8.err}, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            seen = seen | b8.out_valid;
        end
        chk("aborted MUL never presented", seen, 0);
        chk("outputs after abort", {b8.result, b8.flags, b8.err}, 0);
        @(negedge clk);

        // Randomized ops with random consumer stalls.
        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ex = model(8, rop, ra, rb);
            op8(rop, ra, rb, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0, r, f, e, lat);
            chk($sformatf("rnd%0d op%0h result", i, rop), r, ex.res);
            chk($sformatf("rnd%0d op%0h flags", i, rop), f, ex.flg);
            chk($sformatf("rnd%0d op%0h err", i, rop), e, ex.err);
            chk($sformatf("rnd%0d op%0h latency", i, rop), lat, ex.lat);
        end

        // WIDTH=16 instance.
        op16(OP_MUL, 16'd300, 16'd300, r16, f, e, lat);
        chk("w16 MUL result", r16, 16'h5F90);
        chk("w16 MUL flags", f, 4'b1100);
        chk("w16 MUL latency", lat, 17);
        op16(OP_DIV, 16'd1000, 16'd10, r16, f, e, lat);
        chk("w16 DIV result", r16, DIVMOD ? 100 : 0);
        chk("w16 DIV err", e, DIVMOD ? 0 : 1);
        chk("w16 DIV latency", lat, DIVMOD ? 17 : 1);
        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(1, 12));
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            ex = model(16, rop, ra16, rb16);
            op16(rop, ra16, rb16, r16, f, e, lat);
            chk($sformatf("w16 rnd%0d op%0h result", i, rop), r16, ex.res);
            chk($sformatf("w16 rnd%0d op%0h flags", i, rop), f, ex.flg);
            chk($sformatf("w16 rnd%0d op%0h latency", i, rop), lat, ex.lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
